// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - direct-mapped BTB with 2-bit counters, flag-based branch resolve and mispredict redirect
// Optional: define BPU_STATS_EN for the br_count/mp_count branch statistics outputs.
module branch_predict_unit #(
  parameter int ADDR_W  = 16,
  parameter int ENTRIES = 16,
  parameter int IDX_LSB = 2,
  parameter int PC_INCR = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] lu_pc,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              res_valid,
  input  logic [ADDR_W-1:0] res_pc,
  input  logic [2:0]        res_cond,
  input  logic [2:0]        res_flags,
  input  logic [ADDR_W-1:0] res_target,
  input  logic              res_pred_taken,
  input  logic [ADDR_W-1:0] res_pred_target,
  input  logic              bpu_clear,
  output logic              mispredict,
  output logic [ADDR_W-1:0] redirect_pc
`ifdef BPU_STATS_EN
  ,
  output logic [15:0]       br_count,
  output logic [15:0]       mp_count
`endif
);

  localparam int IW = $clog2(ENTRIES);
  localparam int TW = ADDR_W - IDX_LSB - IW;

  logic [ENTRIES-1:0] valid_q;
  logic [1:0]         ctr_q [ENTRIES];
  logic [TW-1:0]      tag_q [ENTRIES];
  logic [ADDR_W-1:0]  tgt_q [ENTRIES];

  logic [IW-1:0] lu_idx;
  logic [TW-1:0] lu_tag;
  logic          lu_hit;
  logic [IW-1:0] res_idx;
  logic [TW-1:0] res_tag;
  logic          res_hit;
  logic          taken;
  logic          mp_next;
  logic [ADDR_W-1:0] redirect_next;
  logic          unused_lu_bits;

  assign unused_lu_bits = ^lu_pc[IDX_LSB-1:0];

  // Lookup reads the registered table only, so a same-cycle update is not visible.
  assign lu_idx      = lu_pc[IDX_LSB+IW-1:IDX_LSB];
  assign lu_tag      = lu_pc[ADDR_W-1:IDX_LSB+IW];
  assign lu_hit      = valid_q[lu_idx] && (tag_q[lu_idx] == lu_tag);
  assign pred_taken  = lu_hit && ctr_q[lu_idx][1];
  assign pred_target = pred_taken ? tgt_q[lu_idx] : '0;

  assign res_idx = res_pc[IDX_LSB+IW-1:IDX_LSB];
  assign res_tag = res_pc[ADDR_W-1:IDX_LSB+IW];
  assign res_hit = valid_q[res_idx] && (tag_q[res_idx] == res_tag);

  always_comb begin
    logic z, v, n;
    z = res_flags[0];
    v = res_flags[1];
    n = res_flags[2];
    taken = 1'b0;
    case (res_cond)
      3'b000:  taken = ~z;
      3'b001:  taken = z;
      3'b010:  taken = ~(z | n);
      3'b011:  taken = n;
      3'b100:  taken = z | ~n;
      3'b101:  taken = n | z;
      3'b110:  taken = v;
      default: taken = 1'b1;
    endcase
  end

  assign mp_next = res_valid &&
                   ((taken != res_pred_taken) || (taken && (res_pred_target != res_target)));
  assign redirect_next = taken ? res_target : res_pc + ADDR_W'(PC_INCR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= 2'b01;
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
      end
    end else if (bpu_clear) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= 2'b01;
      end
    end else if (res_valid) begin
      if (res_hit) begin
        if (taken) begin
          if (ctr_q[res_idx] != 2'b11) begin
            ctr_q[res_idx] <= ctr_q[res_idx] + 2'b01;
          end
          tgt_q[res_idx] <= res_target;
        end else if (ctr_q[res_idx] != 2'b00) begin
          ctr_q[res_idx] <= ctr_q[res_idx] - 2'b01;
        end
      end else if (taken) begin
        // Allocation evicts whatever aliased into this slot.
        valid_q[res_idx] <= 1'b1;
        tag_q[res_idx]   <= res_tag;
        tgt_q[res_idx]   <= res_target;
        ctr_q[res_idx]   <= 2'b10;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispredict  <= 1'b0;
      redirect_pc <= '0;
    end else begin
      mispredict <= mp_next;
      if (mp_next) begin
        redirect_pc <= redirect_next;
      end
    end
  end

`ifdef BPU_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_count <= '0;
      mp_count <= '0;
    end else begin
      if (res_valid && (br_count != 16'hFFFF)) begin
        br_count <= br_count + 16'd1;
      end
      if (mp_next && (mp_count != 16'hFFFF)) begin
        mp_count <= mp_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// tb/tb_branch_predict_unit.sv - directed-vector bench for branch_predict_unit
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] lu_pc;
  logic        pred_taken;
  logic [15:0] pred_target;
  logic        res_valid;
  logic [15:0] res_pc;
  logic [2:0]  res_cond;
  logic [2:0]  res_flags;
  logic [15:0] res_target;
  logic        res_pred_taken;
  logic [15:0] res_pred_target;
  logic        bpu_clear;
  logic        mispredict;
  logic [15:0] redirect_pc;
`ifdef BPU_STATS_EN
  logic [15:0] br_count;
  logic [15:0] mp_count;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_predict_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .lu_pc           (lu_pc),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .res_valid       (res_valid),
    .res_pc          (res_pc),
    .res_cond        (res_cond),
    .res_flags       (res_flags),
    .res_target      (res_target),
    .res_pred_taken  (res_pred_taken),
    .res_pred_target (res_pred_target),
    .bpu_clear       (bpu_clear),
    .mispredict      (mispredict),
    .redirect_pc     (redirect_pc)
`ifdef BPU_STATS_EN
    ,
    .br_count        (br_count),
    .mp_count        (mp_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resolve(input logic [15:0] pc, input logic [2:0] cond, input logic [2:0] flags,
                         input logic [15:0] tgt, input logic pt, input logic [15:0] ptgt);
    res_valid       = 1'b1;
    res_pc          = pc;
    res_cond        = cond;
    res_flags       = flags;
    res_target      = tgt;
    res_pred_taken  = pt;
    res_pred_target = ptgt;
    tick();
    res_valid = 1'b0;
  endtask

  task automatic chk_mp(input string tag, input logic exp_mp, input logic [15:0] exp_pc);
    chk({tag, "_mp"}, mispredict, exp_mp);
    if (exp_mp) chk({tag, "_redir"}, redirect_pc, exp_pc);
  endtask

  task automatic chk_lu(input string tag, input logic [15:0] pc, input logic exp_t,
                        input logic [15:0] exp_tgt);
    lu_pc = pc;
    #1;
    chk({tag, "_pt"}, pred_taken, exp_t);
    chk({tag, "_ptgt"}, pred_target, exp_tgt);
  endtask

  // {cond, flags{N,V,Z}, expected taken}
  logic [6:0] cv [18];

  initial begin
    cv = '{ {3'b000, 3'b000, 1'b1}, {3'b000, 3'b001, 1'b0},
            {3'b001, 3'b001, 1'b1}, {3'b001, 3'b000, 1'b0},
            {3'b010, 3'b000, 1'b1}, {3'b010, 3'b100, 1'b0}, {3'b010, 3'b001, 1'b0},
            {3'b011, 3'b100, 1'b1}, {3'b011, 3'b000, 1'b0},
            {3'b100, 3'b000, 1'b1}, {3'b100, 3'b100, 1'b0}, {3'b100, 3'b101, 1'b1},
            {3'b101, 3'b100, 1'b1}, {3'b101, 3'b001, 1'b1}, {3'b101, 3'b000, 1'b0},
            {3'b110, 3'b010, 1'b1}, {3'b110, 3'b101, 1'b0},
            {3'b111, 3'b000, 1'b1} };

    rst_n = 1'b0; lu_pc = 16'h0010; res_valid = 1'b0; res_pc = '0; res_cond = '0;
    res_flags = '0; res_target = '0; res_pred_taken = 1'b0; res_pred_target = '0;
    bpu_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    chk_lu("rst_lu", 16'h0010, 1'b0, 16'h0000);
    chk("rst_mp", mispredict, 1'b0);
    chk("rst_redir", redirect_pc, 16'h0000);

    resolve(16'h0010, 3'b111, 3'b000, 16'h0040, 1'b0, 16'h0000);
    chk_mp("alloc", 1'b1, 16'h0040);
    chk_lu("alloc_lu", 16'h0010, 1'b1, 16'h0040);
    tick();
    chk("pulse_end_mp", mispredict, 1'b0);

    resolve(16'h0010, 3'b001, 3'b000, 16'h0040, 1'b1, 16'h0040);
    chk_mp("nt_hit", 1'b1, 16'h0014);
    chk_lu("nt_hit_lu", 16'h0010, 1'b0, 16'h0000);

    resolve(16'h0020, 3'b111, 3'b000, 16'h0080, 1'b0, 16'h0000);
    chk_mp("alloc20", 1'b1, 16'h0080);
    for (int i = 0; i < 4; i++) begin
      resolve(16'h0020, 3'b111, 3'b000, 16'h0080, 1'b1, 16'h0080);
      chk_mp($sformatf("sat11_%0d", i), 1'b0, 16'h0000);
    end
    resolve(16'h0020, 3'b001, 3'b000, 16'h0080, 1'b1, 16'h0080);
    chk_mp("dec11", 1'b1, 16'h0024);
    chk_lu("dec11_lu", 16'h0020, 1'b1, 16'h0080);
    resolve(16'h0020, 3'b111, 3'b000, 16'h0090, 1'b1, 16'h0080);
    chk_mp("tgt_rewrite", 1'b1, 16'h0090);
    chk_lu("tgt_rewrite_lu", 16'h0020, 1'b1, 16'h0090);
    for (int i = 0; i < 4; i++) begin
      resolve(16'h0020, 3'b001, 3'b000, 16'h0090, 1'b0, 16'h0000);
      chk_mp($sformatf("dec_%0d", i), 1'b0, 16'h0000);
    end
    resolve(16'h0020, 3'b111, 3'b000, 16'h0090, 1'b0, 16'h0000);
    chk_mp("sat00_inc", 1'b1, 16'h0090);
    chk_lu("sat00_lu", 16'h0020, 1'b0, 16'h0000);

    resolve(16'h0050, 3'b111, 3'b000, 16'h0100, 1'b0, 16'h0000);
    chk_mp("alias", 1'b1, 16'h0100);
    chk_lu("alias_old", 16'h0010, 1'b0, 16'h0000);
    chk_lu("alias_new", 16'h0050, 1'b1, 16'h0100);
    resolve(16'hFFFC, 3'b000, 3'b001, 16'h1234, 1'b1, 16'h1234);
    chk_mp("wrap", 1'b1, 16'h0000);
    chk_lu("miss_nt_lu", 16'hFFFC, 1'b0, 16'h0000);

    for (int i = 0; i < 18; i++) begin
      resolve(16'h0400, cv[i][6:4], cv[i][3:1], 16'h0800, 1'b0, 16'h0000);
      chk_mp($sformatf("cond%0d_f%0d", cv[i][6:4], cv[i][3:1]), cv[i][0], 16'h0800);
    end

    lu_pc = 16'h0044;
    res_valid = 1'b1; res_pc = 16'h0044; res_cond = 3'b111; res_flags = 3'b000;
    res_target = 16'h0200; res_pred_taken = 1'b0; res_pred_target = 16'h0000;
    #1 chk("nobypass_pt", pred_taken, 1'b0);
    tick();
    res_valid = 1'b0;
    chk_lu("after_upd", 16'h0044, 1'b1, 16'h0200);

    bpu_clear = 1'b1;
    tick();
    bpu_clear = 1'b0;
    chk_lu("clear_lu", 16'h0050, 1'b0, 16'h0000);

    resolve(16'h0400, 3'b111, 3'b000, 16'h0800, 1'b0, 16'h0000);
    chk_mp("pre_areset", 1'b1, 16'h0800);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_mp", mispredict, 1'b0);
    chk("areset_redir", redirect_pc, 16'h0000);
    chk_lu("areset_lu", 16'h0400, 1'b0, 16'h0000);
    tick();
    rst_n = 1'b1;
    tick();

    bpu_clear = 1'b1;
    resolve(16'h0030, 3'b111, 3'b000, 16'h0070, 1'b0, 16'h0000);
    bpu_clear = 1'b0;
    chk_mp("clr_vs_upd", 1'b1, 16'h0070);
    chk_lu("clr_vs_upd_lu", 16'h0030, 1'b0, 16'h0000);
`ifdef BPU_STATS_EN
    chk("br_count", br_count, 16'd1);
    chk("mp_count", mp_count, 16'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
